pipelined_rca_adder: RTL and testbench
======================================

// Module: pipelined_rca_adder
// PURPOSE
// - Parametrised, pipelined ripple-carry adder. Successor to the single-bit half-adder
//   building block: WIDTH-bit operands, carry-in, carry-out and signed overflow.
// - The carry chain is split into STAGES registered chunks so long adders close timing.
// - Valid/ready handshake on input and output, with full backpressure.
// - Sits between operand producers and the datapath accumulator.
// PARAMETERS
// - WIDTH   default 16  operand/sum width in bits; must be >= 2.
// - STAGES  default 4   pipeline depth; must divide WIDTH. CHUNK = WIDTH/STAGES bits per stage.
// PORTS
// - clk        in   1      single clock; all flops update on its rising edge.
// - rst_n      in   1      reset, asynchronous assert, active-low.
// - in_valid   in   1      operands on a_in/b_in/c_in are valid.
// - in_ready   out  1      adder can accept operands this cycle.
// - a_in       in   WIDTH  operand A.
// - b_in       in   WIDTH  operand B.
// - c_in       in   1      carry-in.
// - out_valid  out  1      s_out/c_out/ovf_out are valid.
// - out_ready  in   1      consumer accepts the result this cycle.
// - s_out      out  WIDTH  sum = (a_in + b_in + c_in) mod 2^WIDTH.
// - c_out      out  1      carry out of bit WIDTH-1.
// - ovf_out    out  1      signed overflow = carry into MSB XOR carry out of MSB.
// BEHAVIOUR
// - Reset (rst_n low, async): every stage valid bit = 0, out_valid = 0, s_out = 0,
//   c_out = 0, ovf_out = 0. in_ready = 1 the first cycle after rst_n is released.
// - Stage k (0..STAGES-1) holds valid_k, carry_k, the sum bits for chunks 0..k,
//   and the not-yet-added upper operand bits (skew registers).
// - Stage k adds chunk k = bits [k*CHUNK +: CHUNK], using the carry registered by stage k-1.
//   Stage 0 uses c_in.
// - Stage STAGES-1 also captures the carry into the MSB, from which ovf_out is formed.
// - Stage advance rule: ready_k = !valid_k || ready_{k+1}; ready_STAGES = out_ready.
//   in_ready = ready_0. Bubbles collapse; a stall never drops or duplicates data.
// - Transfer occurs only when valid && ready on the same edge (input and output alike).
// - Latency: with out_ready held at 1, a result accepted at edge N has out_valid = 1
//   after edge N+STAGES-1... i.e. it is presented STAGES cycles after acceptance.
// - Throughput: one result per cycle when unstalled.
// - Output stability: while out_valid = 1 and out_ready = 0, s_out/c_out/ovf_out are held.
// - Operand inputs are ignored when in_valid = 0 or in_ready = 0.
// - Simultaneous accept and emit in the same cycle on a full pipe is legal and loses nothing.
// - Wrap-around: the sum is modulo 2^WIDTH; the lost bit appears on c_out.
// - Reset mid-operation: all in-flight results are discarded. No output is produced for
//   operands accepted before reset.
// - STAGES = 1 degenerates to one registered full-width ripple adder with latency 1.
// STRUCTURE
// - Shared package: handshake flag localparams, the CHUNK width function, and the
//   WIDTH % STAGES == 0 elaboration check.
// - Sub-module rca_chunk (CHUNK-bit combinational ripple of full adders):
//   inputs a, b, cin; outputs sum, cout, c_msb (carry into the chunk's top bit).
// - Top level: generate-loop of STAGES registers around rca_chunk instances.
// TESTING (WIDTH=8, STAGES=2 unless stated)
// - Reset: hold rst_n = 0, then release -> out_valid = 0, s_out = 8'h00, in_ready = 1.
// - Wrap: a = 8'hFF, b = 8'h01, c_in = 0 -> 2 cycles later: s_out = 8'h00, c_out = 1, ovf_out = 0.
// - Signed overflow: a = 8'h7F, b = 8'h01, c_in = 0 -> s_out = 8'h80, c_out = 0, ovf_out = 1.
//   Also a = 8'h80, b = 8'h80, c_in = 1 -> s_out = 8'h01, c_out = 1, ovf_out = 1.
// - Streaming: send 4 back-to-back ops (0+0, 3+5, 8'hF0+8'h10, 8'hAA+8'h55 with c_in = 1)
//   with out_ready = 1 -> out_valid high for 4 consecutive cycles, results in order:
//   8'h00/0, 8'h08/0, 8'h00/1, 8'h00/1 (sum/c_out).
// - Backpressure: out_ready = 0 with continuous input -> exactly 2 results accepted, then
//   in_ready = 0. Output held stable. Raising out_ready drains in order with no loss or
//   duplicates.
// - Mid-flight reset: accept 2 ops, assert rst_n = 0 for 1 cycle -> out_valid stays 0;
//   neither op is ever emitted.

Source files
------------

// File: rtl/pipelined_rca_adder_pkg.sv
// Shared definitions for the pipelined ripple-carry adder: handshake flag
// values, default geometry, chunk-width helper and the geometry legality check.
package pipelined_rca_adder_pkg;

    localparam int unsigned WIDTH_DEF  = 16;
    localparam int unsigned STAGES_DEF = 4;

    localparam logic HS_IDLE   = 1'b0;
    localparam logic HS_ASSERT = 1'b1;

    // Bits handled by one pipeline stage.
    function automatic int unsigned chunk_w(input int unsigned width, input int unsigned stages);
        return (stages == 0) ? width : width / stages;
    endfunction

    // Legal geometry: at least two bits, at least one stage, stages divide width evenly.
    function automatic bit cfg_ok(input int unsigned width, input int unsigned stages);
        return (width >= 2) && (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/pipelined_rca_adder_if.sv
// Operand/result handshake bundle for the pipelined adder.
//   in_valid/in_ready   : operand handshake (a_in, b_in, c_in)
//   out_valid/out_ready : result handshake  (s_out, c_out, ovf_out)
// master = operand producer + result consumer, slave = the adder.
interface pipelined_rca_adder_if
    import pipelined_rca_adder_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s_out;
    logic             c_out;
    logic             ovf_out;

    modport master (
        output in_valid, a_in, b_in, c_in, out_ready,
        input  in_ready, out_valid, s_out, c_out, ovf_out
    );

    modport slave (
        input  in_valid, a_in, b_in, c_in, out_ready,
        output in_ready, out_valid, s_out, c_out, ovf_out
    );

endinterface

// File: rtl/pipelined_rca_adder_rca_chunk.sv
// Combinational W-bit ripple of full adders (the rca_chunk building block).
//   i_a, i_b   : operand chunks
//   i_cin      : carry into bit 0
//   o_sum_c    : chunk sum
//   o_cout_c   : carry out of the top bit
//   o_c_msb_c  : carry into the top bit (signed-overflow source)
module pipelined_rca_adder_rca_chunk
    import pipelined_rca_adder_pkg::*;
#(
    parameter int unsigned W = chunk_w(WIDTH_DEF, STAGES_DEF)
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_sum_c,
    output logic         o_cout_c,
    output logic         o_c_msb_c
);

    logic [W:0] w_carry;

    // Bit-serial full-adder ripple.
    always_comb begin
        w_carry    = '0;
        o_sum_c    = '0;
        w_carry[0] = i_cin;
        for (int i = 0; i < int'(W); i++) begin
            o_sum_c[i]   = i_a[i] ^ i_b[i] ^ w_carry[i];
            w_carry[i+1] = (i_a[i] & i_b[i]) | (w_carry[i] & (i_a[i] ^ i_b[i]));
        end
    end

    assign o_cout_c  = w_carry[W];
    assign o_c_msb_c = w_carry[W-1];

endmodule

// File: rtl/pipelined_rca_adder.sv
// Pipelined ripple-carry adder: WIDTH-bit a + b + c_in split into STAGES
// registered CHUNK-bit slices, valid/ready handshake with full backpressure.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of pipelined_rca_adder_if (operands in, result out)
// Stage k keeps its valid bit, the carry out of chunk k, the sum bits of
// chunks 0..k and the operand bits still to be added (skew registers).
module pipelined_rca_adder
    import pipelined_rca_adder_pkg::*;
#(
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned STAGES = STAGES_DEF
) (
    input logic                  clk,
    input logic                  rst_n,
    pipelined_rca_adder_if.slave bus
);

    localparam int unsigned CHUNK = chunk_w(WIDTH, STAGES);

    if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
        $error("pipelined_rca_adder: WIDTH must be >= 2 and divisible by STAGES");
    end

    // w_ready[k] = stage k may load this cycle; w_ready[STAGES] is the consumer.
    logic [STAGES:0] w_ready;

    assign w_ready[STAGES] = bus.out_ready;
    assign bus.in_ready    = w_ready[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned SW = (k + 1) * CHUNK;
        localparam int unsigned RW = WIDTH - k * CHUNK;

        logic             r_valid;
        logic             r_carry;
        logic [SW-1:0]    r_sum;

        logic             w_in_valid;
        logic             w_in_carry;
        logic             w_load;
        logic [RW-1:0]    w_a_rem;
        logic [RW-1:0]    w_b_rem;
        logic [CHUNK-1:0] w_sum_chunk;
        logic [SW-1:0]    w_sum_next;
        logic             w_cout;
        logic             w_c_msb;

        // Stage input: the interface for stage 0, the previous stage otherwise.
        if (k == 0) begin : g_head
            assign w_in_valid = bus.in_valid;
            assign w_in_carry = bus.c_in;
            assign w_a_rem    = bus.a_in;
            assign w_b_rem    = bus.b_in;
            assign w_sum_next = w_sum_chunk;
        end else begin : g_body
            assign w_in_valid = g_stage[k-1].r_valid;
            assign w_in_carry = g_stage[k-1].r_carry;
            assign w_a_rem    = g_stage[k-1].g_skew.r_a_hi;
            assign w_b_rem    = g_stage[k-1].g_skew.r_b_hi;
            assign w_sum_next = {w_sum_chunk, g_stage[k-1].r_sum};
        end

        pipelined_rca_adder_rca_chunk #(
            .W (CHUNK)
        ) u_rca_chunk (
            .i_a       (w_a_rem[CHUNK-1:0]),
            .i_b       (w_b_rem[CHUNK-1:0]),
            .i_cin     (w_in_carry),
            .o_sum_c   (w_sum_chunk),
            .o_cout_c  (w_cout),
            .o_c_msb_c (w_c_msb)
        );

        // A stage can load when empty or when its content moves on this edge.
        assign w_ready[k] = (r_valid == HS_IDLE) || w_ready[k+1];
        assign w_load     = (w_in_valid == HS_ASSERT) && w_ready[k];

        // Valid follows the upstream slot; data only changes on a real transfer.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_valid <= HS_IDLE;
                r_carry <= 1'b0;
                r_sum   <= '0;
            end else begin
                if (w_ready[k]) begin
                    r_valid <= w_in_valid;
                end
                if (w_load) begin
                    r_carry <= w_cout;
                    r_sum   <= w_sum_next;
                end
            end
        end

        if (k < STAGES - 1) begin : g_skew
            logic [RW-CHUNK-1:0] r_a_hi;
            logic [RW-CHUNK-1:0] r_b_hi;
            logic                w_unused_c_msb;

            assign w_unused_c_msb = w_c_msb;

            // Operand bits for the chunks still ahead.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a_hi <= '0;
                    r_b_hi <= '0;
                end else if (w_load) begin
                    r_a_hi <= w_a_rem[RW-1:CHUNK];
                    r_b_hi <= w_b_rem[RW-1:CHUNK];
                end
            end
        end else begin : g_tail
            logic r_ovf;

            // Signed overflow: carry into the MSB differs from carry out of it.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ovf <= 1'b0;
                end else if (w_load) begin
                    r_ovf <= w_cout ^ w_c_msb;
                end
            end
        end
    end

    assign bus.out_valid = g_stage[STAGES-1].r_valid;
    assign bus.s_out     = g_stage[STAGES-1].r_sum;
    assign bus.c_out     = g_stage[STAGES-1].r_carry;
    assign bus.ovf_out   = g_stage[STAGES-1].g_tail.r_ovf;

endmodule

// File: tb/tb_pipelined_rca_adder.sv
// Directed self-checking bench for pipelined_rca_adder (WIDTH=8, STAGES=2).
module tb_pipelined_rca_adder;

    localparam int unsigned W = 8;
    localparam int unsigned S = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    pipelined_rca_adder_if #(.WIDTH(W)) bus ();

    pipelined_rca_adder #(
        .WIDTH  (W),
        .STAGES (S)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid = 1'b0;
        bus.a_in     = '0;
        bus.b_in     = '0;
        bus.c_in     = 1'b0;
    endtask

    task automatic drive_op(input logic [7:0] a, input logic [7:0] b, input logic c);
        bus.in_valid = 1'b1;
        bus.a_in     = a;
        bus.b_in     = b;
        bus.c_in     = c;
    endtask

    // One isolated operation with out_ready high; returns what came out and when.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                          output logic [7:0] s, output logic co, output logic ov,
                          output int lat, output bit acc, output bit timeout);
        bus.out_ready = 1'b1;
        drive_op(a, b, c);
        #1;
        acc = bus.in_ready;
        tick();
        idle_inputs();
        lat = 1;
        while (!bus.out_valid && lat < 10) begin
            tick();
            lat++;
        end
        timeout = !bus.out_valid;
        s  = bus.s_out;
        co = bus.c_out;
        ov = bus.ovf_out;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_held_valid: got %b want 0", bus.out_valid); end
        rst_n = 1'b1;
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        total++; if (bus.s_out !== 8'h00) begin bad++; $display("FAIL reset_s_out: got %h want 00", bus.s_out); end
        total++; if (bus.c_out !== 1'b0 || bus.ovf_out !== 1'b0) begin bad++; $display("FAIL reset_flags: got c=%b ovf=%b want 0/0", bus.c_out, bus.ovf_out); end
        tick();
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_wrap();
        logic [7:0] s; logic co, ov; int lat; bit acc, to;
        run_op(8'hFF, 8'h01, 1'b0, s, co, ov, lat, acc, to);
        total++; if (!acc || to) begin bad++; $display("FAIL wrap_handshake: got acc=%0d timeout=%0d want 1/0", acc, to); end
        total++; if (lat != int'(S)) begin bad++; $display("FAIL wrap_latency: got %0d want %0d", lat, S); end
        total++; if (s !== 8'h00 || co !== 1'b1 || ov !== 1'b0) begin bad++; $display("FAIL wrap_result: got s=%h c=%b ovf=%b want 00/1/0", s, co, ov); end
    endtask

    task automatic test_signed_ovf();
        logic [7:0] va [2] = '{8'h7F, 8'h80};
        logic [7:0] vb [2] = '{8'h01, 8'h80};
        logic       vc [2] = '{1'b0, 1'b1};
        logic [7:0] es [2] = '{8'h80, 8'h01};
        logic       ec [2] = '{1'b0, 1'b1};
        logic       eo [2] = '{1'b1, 1'b1};
        logic [7:0] s; logic co, ov; int lat; bit acc, to;
        for (int i = 0; i < 2; i++) begin
            run_op(va[i], vb[i], vc[i], s, co, ov, lat, acc, to);
            total++; if (to) begin bad++; $display("FAIL ovf_timeout[%0d]: got timeout want result", i); end
            total++; if (s !== es[i] || co !== ec[i] || ov !== eo[i]) begin
                bad++; $display("FAIL ovf_result[%0d]: got s=%h c=%b ovf=%b want %h/%b/%b", i, s, co, ov, es[i], ec[i], eo[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] va [4] = '{8'h00, 8'h03, 8'hF0, 8'hAA};
        logic [7:0] vb [4] = '{8'h00, 8'h05, 8'h10, 8'h55};
        logic       vc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [7:0] es [4] = '{8'h00, 8'h08, 8'h00, 8'h00};
        logic       ec [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        int got   = 0;
        int first = -1;
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (cyc < 4) drive_op(va[cyc], vb[cyc], vc[cyc]);
            else         idle_inputs();
            #1;
            if (cyc < 4) begin
                total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", cyc, bus.in_ready); end
            end
            if (bus.out_valid === 1'b1) begin
                if (got >= 4) begin
                    total++; bad++; $display("FAIL b2b_extra: got extra result %h want none", bus.s_out);
                end else begin
                    if (first < 0) first = cyc;
                    total++; if (cyc != first + got) begin bad++; $display("FAIL b2b_gap[%0d]: got cycle %0d want %0d", got, cyc, first + got); end
                    total++; if (bus.s_out !== es[got] || bus.c_out !== ec[got] || bus.ovf_out !== 1'b0) begin
                        bad++; $display("FAIL b2b_result[%0d]: got %h/%b/%b want %h/%b/0", got, bus.s_out, bus.c_out, bus.ovf_out, es[got], ec[got]);
                    end
                    got++;
                end
            end
            tick();
        end
        total++; if (got != 4) begin bad++; $display("FAIL b2b_count: got %0d want 4", got); end
    endtask

    task automatic test_backpressure();
        logic [7:0] pa [5] = '{8'h10, 8'hFF, 8'h40, 8'h01, 8'hC0};
        logic [7:0] pb [5] = '{8'h20, 8'hFF, 8'h40, 8'h02, 8'hC0};
        logic       pc [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [7:0] es [5] = '{8'h30, 8'hFF, 8'h80, 8'h04, 8'h80};
        logic       ec [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic       eo [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        int idx = 0;
        int got = 0;
        bus.out_ready = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            drive_op(pa[idx], pb[idx], pc[idx]);
            #1;
            if (bus.in_ready === 1'b1) idx++;
            if (cyc >= 2) begin
                total++; if (bus.out_valid !== 1'b1 || bus.s_out !== es[0] || bus.c_out !== ec[0] || bus.ovf_out !== eo[0]) begin
                    bad++; $display("FAIL bp_hold[%0d]: got v=%b %h/%b/%b want 1 %h/%b/%b", cyc, bus.out_valid, bus.s_out, bus.c_out, bus.ovf_out, es[0], ec[0], eo[0]);
                end
            end
            tick();
        end
        total++; if (idx != 2) begin bad++; $display("FAIL bp_accepted: got %0d want 2", idx); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got %b want 0", bus.in_ready); end
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 30 && got < 5; cyc++) begin
            if (idx < 5) drive_op(pa[idx], pb[idx], pc[idx]);
            else         idle_inputs();
            #1;
            if (bus.out_valid === 1'b1) begin
                total++; if (bus.s_out !== es[got] || bus.c_out !== ec[got] || bus.ovf_out !== eo[got]) begin
                    bad++; $display("FAIL bp_drain[%0d]: got %h/%b/%b want %h/%b/%b", got, bus.s_out, bus.c_out, bus.ovf_out, es[got], ec[got], eo[got]);
                end
                got++;
            end
            if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) idx++;
            tick();
        end
        idle_inputs();
        #1;
        total++; if (got != 5 || idx != 5) begin bad++; $display("FAIL bp_drain_count: got out=%0d in=%0d want 5/5", got, idx); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty: got out_valid=%b want 0", bus.out_valid); end
        tick();
    endtask

    task automatic test_midflight_reset();
        bus.out_ready = 1'b0;
        drive_op(8'h11, 8'h22, 1'b0);
        tick();
        drive_op(8'h33, 8'h44, 1'b1);
        tick();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0 || bus.s_out !== 8'h00) begin
            bad++; $display("FAIL midrst_clear: got v=%b s=%h want 0/00", bus.out_valid, bus.s_out);
        end
        tick();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            #1;
            total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_ghost[%0d]: got out_valid=%b want 0", cyc, bus.out_valid); end
            tick();
        end
    endtask

    task automatic test_after_reset();
        logic [7:0] s; logic co, ov; int lat; bit acc, to;
        run_op(8'h03, 8'h05, 1'b0, s, co, ov, lat, acc, to);
        total++; if (to || lat != int'(S)) begin bad++; $display("FAIL post_rst_latency: got lat=%0d timeout=%0d want %0d/0", lat, to, S); end
        total++; if (s !== 8'h08 || co !== 1'b0 || ov !== 1'b0) begin bad++; $display("FAIL post_rst_result: got %h/%b/%b want 08/0/0", s, co, ov); end
    endtask

    initial begin
        idle_inputs();
        bus.out_ready = 1'b0;
        test_reset();
        test_wrap();
        test_signed_ovf();
        test_back_to_back();
        test_backpressure();
        test_midflight_reset();
        test_after_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
